inst_decode_stage: RTL
======================

// Module: inst_decode_stage
// PURPOSE
//  Stage-2 front end: IF/ID pipeline register plus opcode/funct decode producing one-hot inst* strobes.
//  Its outputs feed the format detector and immediate generator directly, so those stay combinational.
//  Uses valid/ready on both sides and a 1-entry skid buffer, so in_ready is a registered signal.
//  Flush supports branch/jump redirect.
// PARAMETERS
//  PC_W      32   width of program counter carried alongside the instruction
//  ABS_OPC   7'b0001011   opcode of custom ABS (custom-0 space)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      kill all held instructions (redirect)
//  in_valid   in   1      fetch offers instruction
//  in_ready   out  1      stage can accept (registered)
//  in_inst    in   32     raw RV32 instruction word
//  in_pc      in   PC_W   PC of in_inst
//  out_valid  out  1      decoded instruction present
//  out_ready  in   1      downstream consumes this cycle
//  out_inst   out  32     held instruction word (immediate generator reads this)
//  out_pc     out  PC_W   held PC
//  inst_add, inst_xor, inst_slt, inst_auipc, inst_lui, inst_addi, inst_lw, inst_andi,
//  inst_srai, inst_beq, inst_jal, inst_sw, inst_abs   out 1 each  one-hot decode strobes
//  illegal    out  1      out_valid and no strobe matched
// BEHAVIOUR
//  Reset (async, rst=1): out_valid=0, in_ready=1, skid empty, out_inst=32'h00000013 (NOP), out_pc=0,
//   all strobes 0, illegal=0.
//  Decode table, fixed: [6:0]=op, [14:12]=f3, [31:25]=f7.
//   ADD  op=0110011 f3=000 f7=0000000 | XOR f3=100 f7=0 | SLT f3=010 f7=0
//   ABS  op=ABS_OPC f3=000 f7=0 rs2=0
//   AUIPC 0010111 | LUI 0110111 | JAL 1101111
//   ADDI 0010011 f3=000 | ANDI f3=111 | SRAI f3=101 f7=0100000
//   LW 0000011 f3=010 | SW 0100011 f3=010 | BEQ 1100011 f3=000
//   Any other encoding: no strobe asserted; illegal=1.
//  Strobes are decoded from the registered out_inst and gated by out_valid.
//   At most one strobe is high; all are 0 when out_valid=0.
//  Handshake: accept when in_valid&in_ready. Output transfer when out_valid&out_ready.
//   Latency: accepted instr appears on out_* the next cycle if the output reg is empty or draining.
//   Output reg stalled (out_valid&~out_ready) and an accept occurs: word goes to skid;
//    in_ready drops the next cycle.
//   Skid full: in_ready=0. On output transfer the skid moves to the output reg; in_ready returns to 1
//    the next cycle.
//   out_* stable while out_valid&~out_ready (no change of inst/pc/strobes).
//   Order preserved; no duplication or loss.
//  flush: synchronous, highest priority. Next cycle out_valid=0, skid empty, in_ready=1.
//   An instruction offered in the flush cycle is discarded.
//  rst mid-transfer: all held instructions dropped immediately (async).
// STRUCTURE
//  Shared package rv_decode_pkg: OPC_* / F3_* / F7_* localparams, NOP constant, ABS_OPC default.
//  Sub-module inst_decoder: combinational 32b word -> 13 strobes + illegal.
//   Reused by the format detector's test bench.
//  Top: output reg + skid reg + valid/ready control.
// TESTING
//  Reset: rst=1 mid-stream -> out_valid=0, in_ready=1, strobes 0, out_inst=00000013.
//  Decode sweep, out_ready=1:
//   00B50533 -> inst_add. 40105093 -> inst_srai. 0000006F -> inst_jal. 00000033 -> inst_add.
//   0000000B (ABS) -> inst_abs. FFFFFFFF -> illegal=1, no strobe.
//  Back-pressure: stream 3 instrs, hold out_ready=0 for 3 cycles
//   -> 2 held, in_ready=0, third waits; release -> all delivered in order, PCs 0,4,8.
//  Flush with skid full -> next cycle out_valid=0, in_ready=1; no stale instr later appears.
//  Throughput: in_valid=1, out_ready=1 continuous -> one instr/cycle, latency 1, in_ready never drops.
//  Random valid/ready/flush, 10k cycles: scoreboard checks order, one-hot strobes,
//   and out_* stability while stalled.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32 decode constants and the strobe bundle produced by inst_decoder.
package rv_decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] ABS_OPC_DEFAULT = 7'b0001011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic is_add;
    logic is_xor;
    logic is_slt;
    logic is_auipc;
    logic is_lui;
    logic is_addi;
    logic is_lw;
    logic is_andi;
    logic is_srai;
    logic is_beq;
    logic is_jal;
    logic is_sw;
    logic is_abs;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/inst_decoder.sv
// Pure combinational RV32 subset decode: one instruction word to one-hot strobes + illegal.
module inst_decoder
  import rv_decode_pkg::*;
#(
  parameter logic [6:0] ABS_OPC = ABS_OPC_DEFAULT
) (
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rs2;
  logic       unused_bits;

  assign op  = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];
  assign rs2 = inst[24:20];
  assign unused_bits = ^{inst[19:15], inst[11:7]};

  always_comb begin
    dec = '0;
    case (op)
      OPC_OP: begin
        dec.is_add = (f3 == F3_ADD) && (f7 == F7_ZERO);
        dec.is_xor = (f3 == F3_XOR) && (f7 == F7_ZERO);
        dec.is_slt = (f3 == F3_SLT) && (f7 == F7_ZERO);
      end
      OPC_OPIMM: begin
        dec.is_addi = (f3 == F3_ADD);
        dec.is_andi = (f3 == F3_AND);
        dec.is_srai = (f3 == F3_SR) && (f7 == F7_ALT);
      end
      OPC_AUIPC:  dec.is_auipc = 1'b1;
      OPC_LUI:    dec.is_lui   = 1'b1;
      OPC_JAL:    dec.is_jal   = 1'b1;
      OPC_LOAD:   dec.is_lw    = (f3 == F3_W);
      OPC_STORE:  dec.is_sw    = (f3 == F3_W);
      OPC_BRANCH: dec.is_beq   = (f3 == F3_BEQ);
      default: ;
    endcase
    // ABS lives in custom space, so it is matched outside the case to tolerate any ABS_OPC value
    if (op == ABS_OPC && f3 == 3'b000 && f7 == F7_ZERO && rs2 == 5'd0)
      dec.is_abs = 1'b1;
    dec.illegal = ~|{dec.is_add, dec.is_xor, dec.is_slt, dec.is_auipc, dec.is_lui,
                     dec.is_addi, dec.is_lw, dec.is_andi, dec.is_srai, dec.is_beq,
                     dec.is_jal, dec.is_sw, dec.is_abs};
  end

endmodule

// File: rtl/inst_decode_stage.sv
// IF/ID pipeline register with a one-entry skid buffer and decode of the held instruction.
module inst_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int         PC_W    = 32,
  parameter logic [6:0] ABS_OPC = ABS_OPC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic            inst_add,
  output logic            inst_xor,
  output logic            inst_slt,
  output logic            inst_auipc,
  output logic            inst_lui,
  output logic            inst_addi,
  output logic            inst_lw,
  output logic            inst_andi,
  output logic            inst_srai,
  output logic            inst_beq,
  output logic            inst_jal,
  output logic            inst_sw,
  output logic            inst_abs,
  output logic            illegal
);

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_inst_q,  out_inst_d;
  logic [PC_W-1:0] out_pc_q,    out_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_inst_q,  skid_inst_d;
  logic [PC_W-1:0] skid_pc_q,    skid_pc_d;
  logic            in_ready_q,   in_ready_d;

  logic accept;
  dec_t dec, dec_g;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output reg is free this edge; the skid entry is older so it wins.
      // in_ready is low whenever the skid is full, so no accept can collide here.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_inst_d   = skid_inst_q;
        out_pc_d     = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_inst_d  = in_inst;
        out_pc_d    = in_pc;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = in_inst;
      skid_pc_d    = in_pc;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_inst_q   <= NOP;
      out_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP;
      skid_pc_q    <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      in_ready_q   <= in_ready_d;
    end
  end

  inst_decoder #(.ABS_OPC(ABS_OPC)) u_dec (
    .inst (out_inst_q),
    .dec  (dec)
  );

  assign dec_g = out_valid_q ? dec : '0;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_inst   = out_inst_q;
  assign out_pc     = out_pc_q;
  assign inst_add   = dec_g.is_add;
  assign inst_xor   = dec_g.is_xor;
  assign inst_slt   = dec_g.is_slt;
  assign inst_auipc = dec_g.is_auipc;
  assign inst_lui   = dec_g.is_lui;
  assign inst_addi  = dec_g.is_addi;
  assign inst_lw    = dec_g.is_lw;
  assign inst_andi  = dec_g.is_andi;
  assign inst_srai  = dec_g.is_srai;
  assign inst_beq   = dec_g.is_beq;
  assign inst_jal   = dec_g.is_jal;
  assign inst_sw    = dec_g.is_sw;
  assign inst_abs   = dec_g.is_abs;
  assign illegal    = dec_g.illegal;

endmodule
